// File: rtl/ld3320_asr_run_result_if.sv
`timescale 1ns/1ps
// Register-access channel between an LD3320 sequencing stage (master) and
// the shared LD3320WriteRead bus engine (slave).
interface ld3320_asr_run_result_if;
    logic       reg_ena;
    logic       reg_sel;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_done;
    logic [7:0] reg_rdata;

    modport master (
        output reg_ena,
        output reg_sel,
        output reg_addr,
        output reg_wdata,
        input  reg_done,
        input  reg_rdata
    );

    modport slave (
        input  reg_ena,
        input  reg_sel,
        input  reg_addr,
        input  reg_wdata,
        output reg_done,
        output reg_rdata
    );
endinterface

// File: rtl/ld3320_asr_run_result.sv
`timescale 1ns/1ps
// Runs one LD3320 ASR pass: start writes, busy poll, IRQ wait, result read, clear, report.
// Optional IRQ watchdog is built when LD3320_ASR_TIMEOUT_EN is defined.
module ld3320_asr_run_result #(
    parameter logic [7:0]  MIC_VOL    = 8'h43,
    parameter logic [15:0] DLY_CYCLES = 16'd50000,
    parameter logic [3:0]  BUSY_RETRY = 4'd10
`ifdef LD3320_ASR_TIMEOUT_EN
    ,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd250000000
`endif
) (
    input  logic                           clk,
    input  logic                           sys_rstn,
    input  logic                           ena,
    input  logic                           irq_n,
    ld3320_asr_run_result_if.master        bus,
    output logic                           busy,
    output logic                           result_valid,
    output logic [7:0]                     result_code,
    output logic                           no_match,
    output logic                           err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RUN1,
        S_POLL,
        S_RUN2,
        S_WAIT_IRQ,
        S_RD_2B,
        S_RD_B2,
        S_RD_BA,
        S_RD_C5,
        S_CLR,
        S_REPORT
    } state_t;

    typedef enum logic [1:0] {
        PH_ISSUE,
        PH_WAIT,
        PH_DLY
    } phase_t;

    typedef struct packed {
        logic       dly;
        logic [7:0] addr;
        logic [7:0] data;
    } wr_entry_t;

    localparam logic [7:0] ASR_IDLE = 8'h21;

    // Write tables for RUN1, RUN2 and CLR; a dly entry is a pause with no bus access.
    function automatic wr_entry_t table_entry(input state_t st, input logic [3:0] step);
        wr_entry_t e;
        e = '{1'b0, 8'h00, 8'h00};
        case (st)
            S_RUN1: begin
                case (step)
                    4'd0:    e = '{1'b0, 8'h35, MIC_VOL};
                    4'd1:    e = '{1'b0, 8'h1C, 8'h09};
                    4'd2:    e = '{1'b0, 8'hBD, 8'h20};
                    4'd3:    e = '{1'b0, 8'h08, 8'h01};
                    4'd4:    e = '{1'b1, 8'h00, 8'h00};
                    4'd5:    e = '{1'b0, 8'h08, 8'h00};
                    4'd6:    e = '{1'b1, 8'h00, 8'h00};
                    default: e = '{1'b0, 8'h00, 8'h00};
                endcase
            end
            S_RUN2: begin
                case (step)
                    4'd0:    e = '{1'b0, 8'hB2, 8'hFF};
                    4'd1:    e = '{1'b0, 8'h37, 8'h06};
                    4'd2:    e = '{1'b1, 8'h00, 8'h00};
                    4'd3:    e = '{1'b0, 8'h1C, 8'h0B};
                    4'd4:    e = '{1'b0, 8'h29, 8'h10};
                    4'd5:    e = '{1'b0, 8'hBD, 8'h00};
                    default: e = '{1'b0, 8'h00, 8'h00};
                endcase
            end
            S_CLR: begin
                case (step)
                    4'd0:    e = '{1'b0, 8'h29, 8'h00};
                    4'd1:    e = '{1'b0, 8'h02, 8'h00};
                    4'd2:    e = '{1'b0, 8'h2B, 8'h00};
                    4'd3:    e = '{1'b0, 8'h1C, 8'h00};
                    default: e = '{1'b0, 8'h00, 8'h00};
                endcase
            end
            default: e = '{1'b0, 8'h00, 8'h00};
        endcase
        return e;
    endfunction

    function automatic logic [3:0] last_step(input state_t st);
        case (st)
            S_RUN1:  return 4'd6;
            S_RUN2:  return 4'd5;
            S_CLR:   return 4'd3;
            default: return 4'd0;
        endcase
    endfunction

    function automatic state_t table_next(input state_t st);
        case (st)
            S_RUN1:  return S_POLL;
            S_RUN2:  return S_WAIT_IRQ;
            S_CLR:   return S_REPORT;
            default: return S_IDLE;
        endcase
    endfunction

    function automatic logic [7:0] read_addr(input state_t st);
        case (st)
            S_POLL:  return 8'hB2;
            S_RD_2B: return 8'h2B;
            S_RD_B2: return 8'hB2;
            S_RD_BA: return 8'hBA;
            S_RD_C5: return 8'hC5;
            default: return 8'h00;
        endcase
    endfunction

    state_t     state_q, state_d;
    phase_t     phase_q, phase_d;
    logic [3:0] step_q, step_d;
    logic [3:0] retry_q, retry_d;
    logic [15:0] dly_q, dly_d;
    logic [7:0] code_q, code_d;
    logic       no_match_q, no_match_d;
    logic       err_q, err_d;
    logic       irq_meta_q, irq_meta_d;
    logic       irq_sync_q, irq_sync_d;
`ifdef LD3320_ASR_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;
`endif

    logic       reg_ena;
    logic       reg_sel;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       step_done;
    logic       dly_last;
    logic [3:0] retry_inc;
    logic [7:0] rdata;
    wr_entry_t  ent;

    assign rdata     = bus.reg_rdata;
    assign dly_last  = (dly_q == DLY_CYCLES - 16'd1);
    assign retry_inc = retry_q + 4'd1;
    assign ent       = table_entry(state_q, step_q);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        phase_d    = phase_q;
        step_d     = step_q;
        retry_d    = retry_q;
        dly_d      = dly_q;
        code_d     = code_q;
        no_match_d = no_match_q;
        err_d      = err_q;
        irq_meta_d = irq_n;
        irq_sync_d = irq_meta_q;
`ifdef LD3320_ASR_TIMEOUT_EN
        tmo_d      = '0;
`endif
        reg_ena    = 1'b0;
        reg_sel    = 1'b0;
        reg_addr   = 8'h00;
        reg_wdata  = 8'h00;
        step_done  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ena) begin
                    state_d    = S_RUN1;
                    phase_d    = PH_ISSUE;
                    step_d     = '0;
                    retry_d    = '0;
                    dly_d      = '0;
                    code_d     = 8'h00;
                    no_match_d = 1'b0;
                    err_d      = 1'b0;
                end
            end

            S_RUN1, S_RUN2, S_CLR: begin
                if (!ent.dly) begin
                    reg_sel   = 1'b1;
                    reg_addr  = ent.addr;
                    reg_wdata = ent.data;
                end
                case (phase_q)
                    PH_ISSUE: begin
                        if (ent.dly) begin
                            phase_d = PH_DLY;
                        end else begin
                            reg_ena = 1'b1;
                            phase_d = PH_WAIT;
                        end
                    end
                    PH_WAIT: step_done = bus.reg_done;
                    PH_DLY: begin
                        if (dly_last) begin
                            dly_d     = '0;
                            step_done = 1'b1;
                        end else begin
                            dly_d = dly_q + 16'd1;
                        end
                    end
                    default: phase_d = PH_ISSUE;
                endcase
                if (step_done) begin
                    phase_d = PH_ISSUE;
                    if (step_q == last_step(state_q)) begin
                        state_d = table_next(state_q);
                        step_d  = '0;
                    end else begin
                        step_d = step_q + 4'd1;
                    end
                end
            end

            S_POLL: begin
                reg_addr = read_addr(state_q);
                case (phase_q)
                    PH_ISSUE: begin
                        reg_ena = 1'b1;
                        phase_d = PH_WAIT;
                    end
                    PH_WAIT: begin
                        if (bus.reg_done) begin
                            if (rdata == ASR_IDLE) begin
                                state_d = S_RUN2;
                                step_d  = '0;
                                phase_d = PH_ISSUE;
                            end else if (retry_inc == BUSY_RETRY) begin
                                retry_d = retry_inc;
                                err_d   = 1'b1;
                                state_d = S_REPORT;
                            end else begin
                                retry_d = retry_inc;
                                phase_d = PH_DLY;
                            end
                        end
                    end
                    PH_DLY: begin
                        if (dly_last) begin
                            dly_d   = '0;
                            phase_d = PH_ISSUE;
                        end else begin
                            dly_d = dly_q + 16'd1;
                        end
                    end
                    default: phase_d = PH_ISSUE;
                endcase
            end

            S_WAIT_IRQ: begin
                // The synchroniser output is sampled directly, so a level already low counts.
                if (!irq_sync_q) begin
                    state_d = S_RD_2B;
                    phase_d = PH_ISSUE;
                end
`ifdef LD3320_ASR_TIMEOUT_EN
                else if (tmo_q == TIMEOUT_CYCLES - 32'd1) begin
                    state_d = S_CLR;
                    step_d  = '0;
                    phase_d = PH_ISSUE;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
`endif
            end

            S_RD_2B, S_RD_B2, S_RD_BA, S_RD_C5: begin
                reg_addr = read_addr(state_q);
                if (phase_q == PH_ISSUE) begin
                    reg_ena = 1'b1;
                    phase_d = PH_WAIT;
                end else if (bus.reg_done) begin
                    phase_d = PH_ISSUE;
                    step_d  = '0;
                    state_d = S_CLR;
                    case (state_q)
                        S_RD_2B: begin
                            if (!rdata[4]) no_match_d = 1'b1;
                            else           state_d    = S_RD_B2;
                        end
                        S_RD_B2: begin
                            if (rdata != ASR_IDLE) no_match_d = 1'b1;
                            else                   state_d    = S_RD_BA;
                        end
                        S_RD_BA: begin
                            if (rdata == 8'd0 || rdata > 8'd4) no_match_d = 1'b1;
                            else                                state_d    = S_RD_C5;
                        end
                        default: code_d = rdata;
                    endcase
                end
            end

            S_REPORT: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: only control state is reset here; there is no storage array that would need it.
    always_ff @(posedge clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q    <= S_IDLE;
            phase_q    <= PH_ISSUE;
            step_q     <= '0;
            retry_q    <= '0;
            dly_q      <= '0;
            code_q     <= 8'h00;
            no_match_q <= 1'b0;
            err_q      <= 1'b0;
            irq_meta_q <= 1'b1;
            irq_sync_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the pre-edge values.
            state_q    <= state_d;
            phase_q    <= phase_d;
            step_q     <= step_d;
            retry_q    <= retry_d;
            dly_q      <= dly_d;
            code_q     <= code_d;
            no_match_q <= no_match_d;
            err_q      <= err_d;
            irq_meta_q <= irq_meta_d;
            irq_sync_q <= irq_sync_d;
        end
    end

`ifdef LD3320_ASR_TIMEOUT_EN
    always_ff @(posedge clk or negedge sys_rstn) begin
        if (!sys_rstn) tmo_q <= '0;
        else           tmo_q <= tmo_d;
    end
`endif

    assign bus.reg_ena   = reg_ena;
    assign bus.reg_sel   = reg_sel;
    assign bus.reg_addr  = reg_addr;
    assign bus.reg_wdata = reg_wdata;

    assign busy         = (state_q != S_IDLE);
    assign result_valid = (state_q == S_REPORT);
    assign result_code  = code_q;
    assign no_match     = no_match_q;
    assign err          = err_q;

endmodule
